// File: rtl/nonce_sweep_ctrl_if.sv
// Hash-core request/response bus between the nonce sweep sequencer and the
// double-SHA-256 header hashing core.
//   core_start  : one-cycle request, sequencer -> core
//   core_header : 640-bit block header, sequencer -> core
//   core_done   : result-valid pulse, core -> sequencer
//   core_hash   : 256-bit digest (numeric big-endian), valid with core_done
interface nonce_sweep_ctrl_if;
   logic         core_start;
   logic [639:0] core_header;
   logic         core_done;
   logic [255:0] core_hash;

   modport master (
      output core_start,
      output core_header,
      input  core_done,
      input  core_hash
   );

   modport slave (
      input  core_start,
      input  core_header,
      output core_done,
      output core_hash
   );
endinterface

// File: rtl/nonce_sweep_ctrl.sv
// Nonce sweep sequencer for the double-SHA-256 header hashing core.
// Builds each header from a latched 608-bit prefix and the current nonce,
// issues it to the core, compares the returned digest against the target and
// stops on the first hit, range exhaustion, abort or core timeout.
//   clk, rst              : clock, asynchronous active-high reset
//   start, abort          : sweep control (start accepted only when idle)
//   header_prefix         : header bytes 0..75, latched on accepted start
//   nonce_first/last      : inclusive sweep range, latched on accepted start
//   target                : hit threshold (hash <= target), latched on start
//   core                  : request/response bus to the hashing core
//   busy, done            : activity level and one-cycle completion pulse
//   found, exhausted,
//   aborted, timed_out    : outcome flags of the last sweep
//   found_nonce, attempts : hit nonce and number of digests checked
module nonce_sweep_ctrl #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [607:0]        header_prefix,
   input  logic [31:0]         nonce_first,
   input  logic [31:0]         nonce_last,
   input  logic [255:0]        target,
   nonce_sweep_ctrl_if.master  core,
   output logic                busy,
   output logic                done,
   output logic                found,
   output logic                exhausted,
   output logic                aborted,
   output logic                timed_out,
   output logic [31:0]         found_nonce,
   output logic [32:0]         attempts
);

   // Counter only has to hold 0..TIMEOUT-1 (TIMEOUT is expected to be >= 2).
   localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StCheck} state_e;

   state_e          state_q;
   logic [607:0]    prefix_q;
   logic [31:0]     nonce_q;
   logic [31:0]     last_q;
   logic [255:0]    target_q;
   logic [255:0]    hash_q;
   logic [CntW-1:0] cnt_q;
   logic            core_start_q;
   logic            busy_q;
   logic            done_q;
   logic            found_q;
   logic            exhausted_q;
   logic            aborted_q;
   logic            timed_out_q;
   logic [31:0]     found_nonce_q;
   logic [32:0]     attempts_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         prefix_q      <= '0;
         nonce_q       <= '0;
         last_q        <= '0;
         target_q      <= '0;
         hash_q        <= '0;
         cnt_q         <= '0;
         core_start_q  <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         found_q       <= 1'b0;
         exhausted_q   <= 1'b0;
         aborted_q     <= 1'b0;
         timed_out_q   <= 1'b0;
         found_nonce_q <= '0;
         attempts_q    <= '0;
      end else begin
         core_start_q <= 1'b0;
         done_q       <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // abort is meaningless here and is ignored
               if (start) begin
                  prefix_q      <= header_prefix;
                  last_q        <= nonce_last;
                  target_q      <= target;
                  nonce_q       <= nonce_first;
                  attempts_q    <= '0;
                  found_q       <= 1'b0;
                  exhausted_q   <= 1'b0;
                  aborted_q     <= 1'b0;
                  timed_out_q   <= 1'b0;
                  found_nonce_q <= '0;
                  cnt_q         <= '0;
                  core_start_q  <= 1'b1;
                  busy_q        <= 1'b1;
                  state_q       <= StIssue;
               end
            end
            StIssue: begin
               if (abort) begin
                  aborted_q <= 1'b1;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= StIdle;
               end else begin
                  // counter tracks cycles since core_start, ISSUE being cycle 0
                  cnt_q   <= cnt_q + CntW'(1);
                  state_q <= StWait;
               end
            end
            StWait: begin
               if (abort) begin
                  aborted_q <= 1'b1;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= StIdle;
               end else if (core.core_done) begin
                  // a response on the last allowed cycle still counts
                  hash_q  <= core.core_hash;
                  state_q <= StCheck;
               end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                  timed_out_q <= 1'b1;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  state_q     <= StIdle;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            StCheck: begin
               if (abort) begin
                  aborted_q <= 1'b1;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= StIdle;
               end else begin
                  attempts_q <= attempts_q + 33'd1;
                  // hit is checked first so the last nonce can still be a hit
                  if (hash_q <= target_q) begin
                     found_q       <= 1'b1;
                     found_nonce_q <= nonce_q;
                     busy_q        <= 1'b0;
                     done_q        <= 1'b1;
                     state_q       <= StIdle;
                  end else if (nonce_q == last_q) begin
                     exhausted_q <= 1'b1;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                     state_q     <= StIdle;
                  end else begin
                     // wraps 0xFFFFFFFF -> 0 for ranges with last < first
                     nonce_q      <= nonce_q + 32'd1;
                     cnt_q        <= '0;
                     core_start_q <= 1'b1;
                     state_q      <= StIssue;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Nonce goes out little-endian in the last four header bytes.
   assign core.core_header = {prefix_q, nonce_q[7:0], nonce_q[15:8],
                              nonce_q[23:16], nonce_q[31:24]};
   assign core.core_start  = core_start_q;

   assign busy        = busy_q;
   assign done        = done_q;
   assign found       = found_q;
   assign exhausted   = exhausted_q;
   assign aborted     = aborted_q;
   assign timed_out   = timed_out_q;
   assign found_nonce = found_nonce_q;
   assign attempts    = attempts_q;

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
module tb_nonce_sweep_ctrl;

   localparam int unsigned TO   = 16;
   localparam int          MAXA = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic [607:0] header_prefix = '0;
   logic [31:0]  nonce_first = '0;
   logic [31:0]  nonce_last = '0;
   logic [255:0] target = '0;
   logic         busy, done, found, exhausted, aborted, timed_out;
   logic [31:0]  found_nonce;
   logic [32:0]  attempts;

   nonce_sweep_ctrl_if core_if ();

   nonce_sweep_ctrl #(.TIMEOUT(TO)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .abort         (abort),
      .header_prefix (header_prefix),
      .nonce_first   (nonce_first),
      .nonce_last    (nonce_last),
      .target        (target),
      .core          (core_if),
      .busy          (busy),
      .done          (done),
      .found         (found),
      .exhausted     (exhausted),
      .aborted       (aborted),
      .timed_out     (timed_out),
      .found_nonce   (found_nonce),
      .attempts      (attempts)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Per-attempt core behaviour: latency (0 = never answers) and digest.
   int           lat [MAXA];
   logic [255:0] hsh [MAXA];

   // Expected timeline of the current sweep.
   bit           m_valid = 1'b0;
   int           m_t = 0;
   int           m_done = 0;
   int           n_iss = 0;
   int           n_chk = 0;
   int           iss_cyc [MAXA];
   int           chk_cyc [MAXA];
   logic [31:0]  iss_nonce [MAXA];
   logic [607:0] m_prefix = '0;
   bit           e_found, e_exh, e_abt, e_to;
   logic [31:0]  e_fn;
   logic [32:0]  e_att;

   // Status visible before the current sweep's start takes effect.
   bit           p_found = 0, p_exh = 0, p_abt = 0, p_to = 0;
   logic [31:0]  p_fn = '0, p_nonce = '0;
   logic [32:0]  p_att = '0;
   logic [607:0] p_prefix = '0;
   int           p_done = -1;

   // Observations made by the core responder.
   int           ri = 0, cd = 0, n_cs = 0, last_cs_cyc = 0;
   logic [255:0] pend = '0;
   logic [31:0]  last_lo = '0;

   task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] bswap(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [607:0] rand608();
      logic [607:0] r;
      for (int i = 0; i < 19; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Hash core model: answers the i-th request of a sweep after lat[i] cycles.
   initial begin
      core_if.core_done = 1'b0;
      core_if.core_hash = '0;
      forever begin
         @(negedge clk);
         core_if.core_done = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               core_if.core_done = 1'b1;
               core_if.core_hash = pend;
            end
         end
         if (!busy) begin
            ri = 0;
            cd = 0;
         end
         if (core_if.core_start && ri < MAXA) begin
            cd          = lat[ri];
            pend        = hsh[ri];
            ri++;
            n_cs++;
            last_lo     = core_if.core_header[31:0];
            last_cs_cyc = cyc;
         end
      end
   end

   // Every cycle: compare all outputs against the expected timeline.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         compare_cycle(cyc);
      end
   end

   task automatic compare_cycle(input int c);
      bit           xb, xs, xd, xf, xe, xa, xt;
      logic [31:0]  xfn, xn;
      logic [32:0]  xat;
      logic [607:0] xp;
      if (!m_valid || c <= m_t) begin
         xb = 0; xs = 0; xd = (c == p_done);
         xf = p_found; xe = p_exh; xa = p_abt; xt = p_to;
         xfn = p_fn; xat = p_att; xn = p_nonce; xp = p_prefix;
      end else if (c < m_done) begin
         xb = 1; xs = 0; xd = 0;
         xf = 0; xe = 0; xa = 0; xt = 0; xfn = '0; xat = '0; xn = '0;
         xp = m_prefix;
         for (int i = 0; i < n_iss; i++) begin
            if (iss_cyc[i] == c) xs = 1;
            if (iss_cyc[i] <= c) xn = iss_nonce[i];
         end
         for (int i = 0; i < n_chk; i++) if (chk_cyc[i] < c) xat++;
      end else begin
         xb = 0; xs = 0; xd = (c == m_done);
         xf = e_found; xe = e_exh; xa = e_abt; xt = e_to;
         xfn = e_fn; xat = e_att; xn = iss_nonce[n_iss-1]; xp = m_prefix;
      end
      check("busy", busy, xb);
      check("core_start", core_if.core_start, xs);
      check("done", done, xd);
      check("found", found, xf);
      check("exhausted", exhausted, xe);
      check("aborted", aborted, xa);
      check("timed_out", timed_out, xt);
      check("found_nonce", found_nonce, xfn);
      check("attempts", attempts, xat);
      check("core_header", core_if.core_header, {xp, bswap(xn)});
   endtask

   task automatic set_plan(input int k, input logic [255:0] h);
      for (int i = 0; i < MAXA; i++) begin
         lat[i] = k;
         hsh[i] = h;
      end
   endtask

   task automatic clear_prev();
      p_found = 0; p_exh = 0; p_abt = 0; p_to = 0;
      p_fn = '0; p_att = '0; p_nonce = '0; p_prefix = '0; p_done = -1;
   endtask

   // Called at a negedge; that cycle is the start cycle. Returns at the negedge
   // of the done cycle (or after a mid-sweep reset when rst_off > 0).
   task automatic run_sweep(input logic [31:0] first, input logic [31:0] last,
                            input logic [255:0] tgt, input int abort_pick,
                            input int spur_off, input int rst_off);
      int           t, a, ic, nat_done, ni, nc;
      logic [607:0] pre;
      logic [31:0]  nx;
      t = cyc;
      pre = rand608();
      if (m_valid) begin
         p_found = e_found; p_exh = e_exh; p_abt = e_abt; p_to = e_to;
         p_fn = e_fn; p_att = e_att; p_nonce = iss_nonce[n_iss-1];
         p_prefix = m_prefix; p_done = m_done;
      end
      ic = t + 1; nat_done = t + 2; ni = 0; nc = 0;
      e_found = 0; e_exh = 0; e_abt = 0; e_to = 0; e_fn = '0;
      for (int i = 0; i < MAXA; i++) begin
         nx = first + 32'(i);
         iss_cyc[i] = ic; iss_nonce[i] = nx; ni = i + 1;
         if (lat[i] == 0 || lat[i] > int'(TO) - 1) begin
            e_to = 1; nat_done = ic + int'(TO);
            break;
         end
         chk_cyc[i] = ic + lat[i] + 1; nc = i + 1;
         nat_done = chk_cyc[i] + 1;
         if (hsh[i] <= tgt) begin
            e_found = 1; e_fn = nx;
            break;
         end
         if (nx == last) begin
            e_exh = 1;
            break;
         end
         ic = chk_cyc[i] + 1;
      end
      a = -1;
      m_done = nat_done;
      if (abort_pick > 0) begin
         a = t + 1 + (abort_pick - 1) % (nat_done - t - 1);
         m_done = a + 1;
         e_found = 0; e_exh = 0; e_to = 0; e_abt = 1; e_fn = '0;
         ni = 0; nc = 0;
         for (int i = 0; i < MAXA; i++) begin
            if (i < n_iss_bound(e_to) && iss_cyc[i] <= a && iss_nonce[i] == first + 32'(i)) ni = i + 1;
         end
         for (int i = 0; i < ni; i++) if (i < MAXA && chk_cyc[i] < a && i < nc_bound(i)) nc = i + 1;
      end
      n_iss = ni; n_chk = nc; e_att = 33'(nc);
      m_prefix = pre; m_t = t; m_valid = 1;
      header_prefix = pre; nonce_first = first; nonce_last = last; target = tgt;
      start = 1'b1;
      while (cyc < m_done) begin
         @(negedge clk);
         start = (spur_off > 0) && (cyc == t + spur_off) && (cyc < m_done);
         abort = (cyc == a);
         header_prefix = rand608(); nonce_first = $urandom; nonce_last = $urandom;
         target = rand256();
         if (rst_off > 0 && cyc == t + rst_off) begin
            rst = 1'b1; start = 1'b0; abort = 1'b0;
            m_valid = 0;
            clear_prev();
            repeat (3) @(negedge clk);
            rst = 1'b0;
            return;
         end
      end
   endtask

   // Helpers bounding the abort truncation to attempts the untruncated
   // timeline actually contains.
   int plan_len = 0;
   function automatic int n_iss_bound(input bit dummy);
      return plan_len;
   endfunction
   int chk_len = 0;
   function automatic int nc_bound(input int i);
      return chk_len;
   endfunction

   task automatic sweep(input logic [31:0] first, input logic [31:0] last,
                        input logic [255:0] tgt, input int abort_pick,
                        input int spur_off, input int rst_off);
      // First pass without abort fixes how many attempts exist.
      int t;
      logic [31:0] nx;
      int ic;
      plan_len = 0; chk_len = 0; ic = 0;
      for (int i = 0; i < MAXA; i++) begin
         nx = first + 32'(i);
         plan_len = i + 1;
         if (lat[i] == 0 || lat[i] > int'(TO) - 1) break;
         chk_len = i + 1;
         if (hsh[i] <= tgt || nx == last) break;
      end
      t = ic;
      run_sweep(first, last, tgt, abort_pick, spur_off, rst_off);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         start = 1'b0;
         abort = ($urandom_range(0, 1) == 1);
      end
   endtask

   initial begin
      logic [255:0] r;
      logic [31:0]  first;
      int           n, cs0;
      set_plan(1, '0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(2);

      // Sweep 5..7 with an all-ones target: first nonce hits.
      set_plan(2, rand256());
      sweep(32'd5, 32'd7, '1, 0, 0, 0);
      check("d1_found", found, 1'b1);
      check("d1_found_nonce", found_nonce, 32'd5);
      check("d1_attempts", attempts, 33'd1);
      check("d1_done", done, 1'b1);
      idle(2);

      // Sweep 0x10..0x13, only nonce 0x12 hits.
      set_plan(3, '1);
      hsh[2] = '0;
      cs0 = n_cs;
      sweep(32'h10, 32'h13, 256'h1000, 0, 0, 0);
      check("d2_issues", 32'(n_cs - cs0), 32'd3);
      check("d2_header_lo", last_lo, 32'h1200_0000);
      check("d2_found_nonce", found_nonce, 32'h12);
      check("d2_attempts", attempts, 33'd3);
      idle(1);

      // Wrap-around sweep, target 0 never hits.
      set_plan(1, 256'd1);
      cs0 = n_cs;
      sweep(32'hFFFF_FFFE, 32'h1, '0, 0, 0, 0);
      check("d3_issues", 32'(n_cs - cs0), 32'd4);
      check("d3_exhausted", exhausted, 1'b1);
      check("d3_found", found, 1'b0);
      check("d3_attempts", attempts, 33'd4);
      idle(2);

      // Single-nonce sweep: equality hits, target+1 does not.
      r = rand256();
      r[255] = 1'b0;
      set_plan(2, r);
      sweep(32'd1, 32'd1, r, 0, 0, 0);
      check("d4_found", found, 1'b1);
      check("d4_attempts", attempts, 33'd1);
      hsh[0] = r + 256'd1;
      sweep(32'd1, 32'd1, r, 0, 0, 0);
      check("d4_exhausted", exhausted, 1'b1);
      check("d4_found_b", found, 1'b0);
      check("d4_attempts_b", attempts, 33'd1);
      idle(2);

      // Abort coincides with a hitting core_done; stray start mid-sweep.
      set_plan(3, '0);
      sweep(32'h100, 32'h104, rand256(), 4, 2, 0);
      check("d5_aborted", aborted, 1'b1);
      check("d5_found", found, 1'b0);
      check("d5_attempts", attempts, 33'd0);
      idle(2);

      // Core never answers.
      set_plan(0, '0);
      sweep(32'd0, 32'd3, rand256(), 0, 0, 0);
      check("d6_timed_out", timed_out, 1'b1);
      check("d6_done", done, 1'b1);
      check("d6_latency", 32'(cyc - last_cs_cyc), 32'd16);
      idle(2);

      // Reset in the middle of a sweep.
      set_plan(2, '1);
      sweep(32'h20, 32'h27, '0, 0, 0, 7);
      check("d7_busy", busy, 1'b0);
      check("d7_attempts", attempts, 33'd0);
      check("d7_header", core_if.core_header, 640'd0);
      idle(2);

      // Randomized sweeps.
      for (int s = 0; s < 40; s++) begin
         if ($urandom_range(0, 3) == 0) first = 32'hFFFF_FFFF - $urandom_range(0, 3);
         else first = $urandom;
         n = $urandom_range(1, 6);
         r = rand256();
         for (int i = 0; i < MAXA; i++) begin
            case ($urandom_range(0, 19))
               0:       lat[i] = 0;
               1:       lat[i] = int'(TO) - 1;
               2:       lat[i] = int'(TO);
               default: lat[i] = $urandom_range(1, 4);
            endcase
            case ($urandom_range(0, 5))
               0:       hsh[i] = r;
               1:       hsh[i] = r + 256'd1;
               2:       hsh[i] = '0;
               3:       hsh[i] = '1;
               default: hsh[i] = rand256();
            endcase
         end
         sweep(first, first + 32'(n - 1), r,
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0,
               ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0, 0);
         if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 4));
      end

      idle(3);
      abort = 1'b0;
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/nonce_sweep_ctrl.md
# nonce_sweep_ctrl

Sequencer that drives the double-SHA-256 header hashing core through a nonce sweep. It builds each 640-bit block header from a fixed 608-bit prefix and the current nonce, and issues it to the core. It then compares the returned 256-bit digest against a target and stops on the first hit, range exhaustion, abort or core timeout. It sits between the top-level mining control and the hashing core, replacing the constant header feed into that core.

## Interface
Parameters:
- TIMEOUT, default 1024: maximum cycles to wait for `core_done` after `core_start`.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: begin a sweep; accepted only in IDLE.
- `abort`, input, 1: cancel an active sweep.
- `header_prefix`, input, 608: header bytes 0..75; sampled on accepted `start`.
- `nonce_first`, input, 32: first nonce; sampled on accepted `start`.
- `nonce_last`, input, 32: last nonce, inclusive; sampled on accepted `start`.
- `target`, input, 256: hit threshold; sampled on accepted `start`.
- `core_start`, output, 1: one-cycle request to the hash core.
- `core_header`, output, 640: header presented to the core.
- `core_done`, input, 1: core result-valid pulse.
- `core_hash`, input, 256: digest, numeric big-endian; valid with `core_done`.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse on the transition into IDLE.
- `found`, output, 1: status flag for the last sweep.
- `exhausted`, output, 1: status flag for the last sweep.
- `aborted`, output, 1: status flag for the last sweep.
- `timed_out`, output, 1: status flag for the last sweep.
- `found_nonce`, output, 32: nonce that produced the hit.
- `attempts`, output, 33: count of digests checked in the current or last sweep.

## Operation
- States:
  - IDLE.
  - ISSUE: drives `core_start` for 1 cycle.
  - WAIT: waits for `core_done`, counting timeout cycles.
  - CHECK: compares the registered digest.
- IDLE, `start` high:
  - Latch the inputs.
  - `nonce` <= `nonce_first`, `attempts` <= 0.
  - Clear all four status flags and `found_nonce`.
  - Go to ISSUE.
- `core_header` = {`header_prefix_latched`, byte-reversed `nonce`}. Bits [31:0] = {nonce[7:0], nonce[15:8], nonce[23:16], nonce[31:24]}.
  - Held stable from ISSUE through CHECK.
- ISSUE -> WAIT unconditionally. The timeout counter resets to 0 on ISSUE.
- WAIT, `core_done` high:
  - Register `core_hash`.
  - Go to CHECK.
- WAIT, counter reaches TIMEOUT-1 without `core_done`:
  - `timed_out` <= 1.
  - Go to IDLE.
- CHECK:
  - `attempts` += 1.
  - Hit is unsigned `hash <= target`.
  - Hit: `found` <= 1, `found_nonce` <= `nonce`, go to IDLE.
  - Else, if `nonce == nonce_last`: `exhausted` <= 1, go to IDLE.
  - Else: `nonce` <= `nonce + 1` (mod 2^32), go to ISSUE.
- Hit takes priority over exhaustion on the last nonce.
- Wrap-around: if `nonce_last < nonce_first`, the sweep passes 0xFFFFFFFF -> 0x00000000. `nonce_first == nonce_last` gives exactly 1 attempt. The full range gives 2^32 attempts (hence the 33-bit `attempts`).
- `abort` in ISSUE/WAIT/CHECK:
  - `aborted` <= 1, go to IDLE next edge.
  - Abort overrides any simultaneous `core_done`, hit, exhaustion or timeout.
  - `attempts` does not increment that cycle.
- `start` while busy is ignored.
- `abort` in IDLE is ignored.
- `core_done` outside WAIT is ignored.
- Status flags, `found_nonce` and `attempts` hold in IDLE until the next accepted `start`.

## Timing
- Reset values:
  - State IDLE.
  - `core_start`, `busy`, `done`, all status flags = 0.
  - `found_nonce`, `attempts`, `nonce` = 0.
  - `core_header` = 0.
- Reset mid-sweep returns immediately (asynchronously) to these values. No `done` pulse.
- `start` sampled at edge T: ISSUE occupies T+1, so `core_start` = 1 for exactly that cycle.
- If the core asserts `core_done` k cycles after `core_start` (k >= 1), CHECK occupies the cycle after `core_done`. Each nonce costs k+2 cycles.
- `done` is high in the first IDLE cycle after CHECK, timeout or abort. `busy` is low in that same cycle.
- A new `start` is accepted in the same cycle `done` is high.
- Timeout: `timed_out` is set TIMEOUT cycles after `core_start`.

## Test plan
- Sweep 5..7, target all-ones: hit on nonce 5, then `found`=1, `found_nonce`=5, `attempts`=1, `done` pulses once.
- Sweep 0x10..0x13 with a core model that hits only at nonce 0x12: 3 `core_start` pulses, `found_nonce`=0x12, `attempts`=3. Check `core_header[31:0]` = 0x12000000 on the third issue.
- Sweep 0xFFFFFFFE..0x00000001, target 0: 4 attempts in order FFFFFFFE, FFFFFFFF, 0, 1, then `exhausted`=1, `found`=0, `attempts`=4.
- Sweep 1..1 with a hash equal to the target: `found`=1 (equality counts as a hit), `attempts`=1. Repeat with hash = target+1: `exhausted`=1.
- `abort` in the same cycle as `core_done` carrying a hit: `aborted`=1, `found`=0, `attempts` unchanged. A `start` pulsed during the sweep has no effect.
- Core model never responds, TIMEOUT=16: `timed_out`=1 and `done` exactly 16 cycles after `core_start`. Assert `rst` during a later sweep and check all outputs return to zero.
